cv32e40p_event_log: RTL and testbench
=====================================

// Module: cv32e40p_event_log
// PURPOSE
//  Parametrised per-hart event monitor/logger; successor to the core illegal-insn logger.
//  Samples NUM_CH qualified event lines (illegal insn, ebreak, ecall, ...) while decoding.
//  Per channel: keeps saturating counters; captures {channel, PC, timestamp} into a FIFO;
//  flags event storms. Optional $display per capture. Sits beside the ID stage, no RTL feedback.
// PARAMETERS
//  NUM_CH        4    number of event channels (1..16)
//  CNT_W         16   per-channel counter width, saturating
//  DEPTH         8    capture FIFO depth, power of 2, >=2
//  TS_W          32   free-running timestamp width, wraps
//  STORM_THRESH  4    consecutive event cycles that enter STORM; also quiet cycles to leave it
//  LOG_EN        1    1: $display each captured entry at negedge clk_i (simulation only)
// PORTS
//  clk_i          in   1             clock
//  rst_ni         in   1             asynchronous active-low reset
//  is_decoding_i  in   1             events qualified only when 1
//  event_i        in   NUM_CH        per-channel event strobes
//  hart_id_i      in   32            hart id (log text only, bits [3:0])
//  pc_id_i        in   32            PC of the instruction in ID
//  clear_i        in   1             sync clear: counters, FIFO, overflow, FSM
//  pop_i          in   1             consume FIFO head
//  entry_valid_o  out  1             FIFO non-empty
//  entry_ch_o     out  $clog2(NUM_CH) head channel index (width min 1)
//  entry_pc_o     out  32            head PC
//  entry_ts_o     out  TS_W          head timestamp
//  count_o        out  NUM_CH*CNT_W  channel c count at [c*CNT_W +: CNT_W]
//  overflow_o     out  1             sticky: capture dropped because FIFO full
//  storm_o        out  1             FSM in STORM
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; ts=0; FSM IDLE. clear_i same effect, sync; clear wins over all.
//  - qev[c] = is_decoding_i & event_i[c]; any = |qev.
//  - Timestamp: ts += 1 every cycle, wraps 2^TS_W-1 -> 0; entry holds ts of capture cycle.
//  - Counters: count[c] += qev[c] each cycle; hold at 2^CNT_W-1; all channels in parallel.
//  - Capture: if any, push {lowest-index set c, pc_id_i, ts}; other set channels count only.
//  - FIFO: head visible combinationally, 1-cycle push-to-valid latency.
//    pop_i with entry_valid_o=0 ignored; pop then push same cycle allowed when full (no overflow).
//    Push with full and no pop: dropped, overflow_o<=1 until clear/reset.
//  - Storm FSM, run/quiet counter r:
//    IDLE   : any -> ACTIVE, r=1.
//    ACTIVE : any -> r++; r reaching STORM_THRESH -> STORM, r=0. !any -> IDLE.
//    STORM  : !any -> r++, any -> r=0; r reaching STORM_THRESH -> IDLE.
//    STORM_THRESH=1: first qualified event enters STORM directly from IDLE.
//  - LOG_EN: "%t: <ch> event (core %0d) at PC 0x%h" on each accepted push; also warn once per overflow set.
//  - Reset mid-operation: immediate, no partial entry survives; counters restart from 0.
// STRUCTURE
//  - cv32e40p_event_log_pkg:
//      typedef struct entry_t {ch, pc, ts}; enum storm_state_e {IDLE, ACTIVE, STORM}.
//  - Sub-module cv32e40p_event_log_fifo #(DEPTH, entry_t): ptrs with wrap bit, full/empty, flush.
//  - Priority encoder, counters, FSM, log process in top; no latches; $display behind LOG_EN generate.
// TESTING
//  1 Reset, no events                  -> all outputs 0; ts increments 1/cycle.
//  2 event_i=4'b0110, decoding, pc=0x80 one cycle -> next cycle: valid=1, ch=1, pc=0x80;
//    count1=count2=1, others 0.
//  3 Nine captures, no pop, DEPTH=8    -> 8 entries kept; overflow_o=1 after 9th; pops return 1st..8th in order.
//  4 Full FIFO, pop_i+event same cycle -> occupancy stays 8, overflow_o stays 0.
//  5 Events 4 consecutive cycles, THRESH=4 -> storm_o=1 on cycle after 4th;
//    4 quiet cycles -> 0; 3 events then gap -> never STORM.
//  6 CNT_W=4, 20 events on ch0         -> count0=15 saturated; clear_i -> all 0, FIFO empty, FSM IDLE.

Source files
------------

// File: rtl/cv32e40p_event_log_pkg.sv
// Shared types for the per-hart event logger.
// Entry fields are sized for the widest legal configuration.
package cv32e40p_event_log_pkg;

    localparam int unsigned CH_W_MAX = 4;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned TS_W_MAX = 64;

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic [PC_W-1:0]     pc;
        logic [TS_W_MAX-1:0] ts;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        STORM
    } storm_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e40p_event_log_fifo.sv
// Capture FIFO with wrap-bit pointers and synchronous flush.
// Head is read combinationally; a pop and push may share a cycle when full.
module cv32e40p_event_log_fifo
    import cv32e40p_event_log_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = entry_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  logic pop_i,
    input  T     data_i,
    output T     data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    T            r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/cv32e40p_event_log.sv
// Per-hart event monitor: saturating counters, capture FIFO and storm FSM.
// Observes the ID stage only; nothing here feeds back into the core.
module cv32e40p_event_log
    import cv32e40p_event_log_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned TS_W         = 32,
    parameter int unsigned STORM_THRESH = 4,
    parameter bit          LOG_EN       = 1'b1,
    localparam int unsigned CH_W        = idx_w(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    is_decoding_i,
    input  logic [NUM_CH-1:0]       event_i,
    input  logic [31:0]             hart_id_i,
    input  logic [31:0]             pc_id_i,
    input  logic                    clear_i,
    input  logic                    pop_i,
    output logic                    entry_valid_o,
    output logic [CH_W-1:0]         entry_ch_o,
    output logic [31:0]             entry_pc_o,
    output logic [TS_W-1:0]         entry_ts_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic                    overflow_o,
    output logic                    storm_o
);

    localparam int unsigned RW = $clog2(STORM_THRESH + 1);

    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic             r_ovf;
    storm_state_e     r_state;
    logic [RW-1:0]    r_run;

    logic [NUM_CH-1:0] w_qev;
    logic              w_any;
    logic [CH_W-1:0]   w_ch;
    entry_t            w_in;
    entry_t            w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_drop;
    logic [RW-1:0]     w_run_inc;
    logic              w_unused;

    assign w_qev     = event_i & {NUM_CH{is_decoding_i}};
    assign w_any     = |w_qev;
    assign w_drop    = w_any & w_full & ~pop_i;
    assign w_run_inc = r_run + RW'(1);
    assign w_unused  = ^{hart_id_i, w_head};

    // Lowest-index qualified channel owns the capture slot.
    always_comb begin
        w_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_qev[c]) w_ch = CH_W'(c);
        end
    end

    always_comb begin
        w_in    = '0;
        w_in.ch = CH_W_MAX'(w_ch);
        w_in.pc = pc_id_i;
        w_in.ts = TS_W_MAX'(r_ts);
    end

    cv32e40p_event_log_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (w_any),
        .pop_i   (pop_i),
        .data_i  (w_in),
        .data_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ts  <= '0;
            r_ovf <= 1'b0;
        end else if (clear_i) begin
            r_ts  <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else if (clear_i) begin
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_qev[c] && (r_cnt[c] != '1)) r_cnt[c] <= r_cnt[c] + 1'b1;
            end
        end
    end

    // r_run counts event cycles in ACTIVE and quiet cycles in STORM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_run   <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_run   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        if (STORM_THRESH == 1) begin
                            r_state <= STORM;
                            r_run   <= '0;
                        end else begin
                            r_state <= ACTIVE;
                            r_run   <= RW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    if (!w_any) begin
                        r_state <= IDLE;
                        r_run   <= '0;
                    end else if (w_run_inc == RW'(STORM_THRESH)) begin
                        r_state <= STORM;
                        r_run   <= '0;
                    end else begin
                        r_run <= w_run_inc;
                    end
                end
                STORM: begin
                    if (w_any) begin
                        r_run <= '0;
                    end else if (w_run_inc == RW'(STORM_THRESH)) begin
                        r_state <= IDLE;
                        r_run   <= '0;
                    end else begin
                        r_run <= w_run_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_run   <= '0;
                end
            endcase
        end
    end

    assign entry_valid_o = ~w_empty;
    assign entry_ch_o    = w_empty ? '0 : w_head.ch[CH_W-1:0];
    assign entry_pc_o    = w_empty ? '0 : w_head.pc;
    assign entry_ts_o    = w_empty ? '0 : w_head.ts[TS_W-1:0];
    assign overflow_o    = r_ovf;
    assign storm_o       = (r_state == STORM);

    always_comb begin
        count_o = '0;
        for (int c = 0; c < NUM_CH; c++) count_o[c*CNT_W +: CNT_W] = r_cnt[c];
    end

    if (LOG_EN) begin : g_log
        always @(negedge clk_i) begin
            if (rst_ni && !clear_i) begin
                if (w_any && (!w_full || pop_i))
                    $display("%t: ch%0d event (core %0d) at PC 0x%h",
                             $time, w_ch, hart_id_i[3:0], pc_id_i);
                if (w_drop && !r_ovf)
                    $display("%t: capture FIFO overflow (core %0d)",
                             $time, hart_id_i[3:0]);
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_event_log.sv
// Randomised and directed bench for cv32e40p_event_log.
// Reference model keeps a queue of entries and plain integer counters.
module tb_cv32e40p_event_log;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 8;
    localparam int THRESH = 4;
    localparam int CH_W   = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    is_decoding_i;
    logic [NUM_CH-1:0]       event_i;
    logic [31:0]             hart_id_i;
    logic [31:0]             pc_id_i;
    logic                    clear_i;
    logic                    pop_i;
    logic                    entry_valid_o;
    logic [CH_W-1:0]         entry_ch_o;
    logic [31:0]             entry_pc_o;
    logic [TS_W-1:0]         entry_ts_o;
    logic [NUM_CH*CNT_W-1:0] count_o;
    logic                    overflow_o;
    logic                    storm_o;

    cv32e40p_event_log #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEPTH        (DEPTH),
        .TS_W         (TS_W),
        .STORM_THRESH (THRESH),
        .LOG_EN       (1'b0)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .is_decoding_i (is_decoding_i),
        .event_i       (event_i),
        .hart_id_i     (hart_id_i),
        .pc_id_i       (pc_id_i),
        .clear_i       (clear_i),
        .pop_i         (pop_i),
        .entry_valid_o (entry_valid_o),
        .entry_ch_o    (entry_ch_o),
        .entry_pc_o    (entry_pc_o),
        .entry_ts_o    (entry_ts_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .storm_o       (storm_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          ch;
        logic [31:0] pc;
        int          ts;
    } m_entry_t;

    int       n_cmp = 0;
    int       n_err = 0;
    m_entry_t mq[$];
    int       m_ts;
    int       m_cnt[NUM_CH];
    bit       m_ovf;
    bit       m_storm;
    int       m_run;
    int       m_quiet;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ts    = 0;
        m_ovf   = 1'b0;
        m_storm = 1'b0;
        m_run   = 0;
        m_quiet = 0;
        for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    endfunction

    function automatic void model_step();
        bit       any;
        m_entry_t e;
        if (clear_i) begin
            model_reset();
            return;
        end
        any = is_decoding_i && (event_i != '0);
        if (pop_i && mq.size() > 0) void'(mq.pop_front());
        if (any) begin
            e.ch = -1;
            for (int c = 0; c < NUM_CH; c++)
                if (event_i[c] && e.ch < 0) e.ch = c;
            e.pc = pc_id_i;
            e.ts = m_ts;
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++)
            if (is_decoding_i && event_i[c] && m_cnt[c] < CMAX) m_cnt[c]++;
        if (!m_storm) begin
            m_run = any ? m_run + 1 : 0;
            if (m_run >= THRESH) begin
                m_storm = 1'b1;
                m_quiet = 0;
            end
        end else begin
            m_quiet = any ? 0 : m_quiet + 1;
            if (m_quiet >= THRESH) begin
                m_storm = 1'b0;
                m_run   = 0;
            end
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
    endfunction

    task automatic check_all(input string pfx);
        bit v;
        v = (mq.size() > 0);
        check({pfx, ".valid"}, 64'(entry_valid_o), 64'(v));
        check({pfx, ".ch"}, 64'(entry_ch_o), v ? 64'(mq[0].ch) : 64'd0);
        check({pfx, ".pc"}, 64'(entry_pc_o), v ? 64'(mq[0].pc) : 64'd0);
        check({pfx, ".ts"}, 64'(entry_ts_o), v ? 64'(mq[0].ts) : 64'd0);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("%s.cnt%0d", pfx, c),
                  64'(count_o[c*CNT_W +: CNT_W]), 64'(m_cnt[c]));
        check({pfx, ".ovf"}, 64'(overflow_o), 64'(m_ovf));
        check({pfx, ".storm"}, 64'(storm_o), 64'(m_storm));
    endtask

    task automatic cyc(input string tag, input bit d, input logic [3:0] e,
                       input logic [31:0] p, input bit clr, input bit pp);
        is_decoding_i = d;
        event_i       = e;
        pc_id_i       = p;
        clear_i       = clr;
        pop_i         = pp;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        is_decoding_i = 1'b0;
        event_i       = '0;
        hart_id_i     = 32'd3;
        pc_id_i       = '0;
        clear_i       = 1'b0;
        pop_i         = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all("reset");
        rst_ni = 1'b1;

        idle("t1_idle", 5);
        cyc("t1_ts", 1'b1, 4'b0001, 32'h44, 1'b0, 1'b0);
        check("t1_ts5", 64'(entry_ts_o), 64'd5);
        cyc("t1_pop", 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);

        cyc("t2_clr", 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        cyc("t2_ev", 1'b1, 4'b0110, 32'h80, 1'b0, 1'b0);
        check("t2_ch", 64'(entry_ch_o), 64'd1);
        check("t2_pc", 64'(entry_pc_o), 64'h80);
        cyc("t2_nodec", 1'b0, 4'b1111, 32'h90, 1'b0, 1'b1);

        cyc("t3_clr", 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            cyc("t3_push", 1'b1, 4'b1000, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        check("t3_ovf", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 9; i++)
            cyc("t3_pop", 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);

        cyc("t4_clr", 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc("t4_fill", 1'b1, 4'b0100, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
        cyc("t4_popush", 1'b1, 4'b0010, 32'h300, 1'b0, 1'b1);
        check("t4_ovf0", 64'(overflow_o), 64'd0);
        for (int i = 0; i < 8; i++)
            cyc("t4_drain", 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);

        cyc("t5_clr", 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc("t5_run", 1'b1, 4'b0001, 32'h400, 1'b0, 1'b1);
        check("t5_storm_on", 64'(storm_o), 64'd1);
        idle("t5_quiet", 4);
        check("t5_storm_off", 64'(storm_o), 64'd0);
        for (int i = 0; i < 3; i++)
            cyc("t5_short", 1'b1, 4'b0001, 32'h500, 1'b0, 1'b1);
        idle("t5_gap", 1);
        check("t5_no_storm", 64'(storm_o), 64'd0);

        cyc("t6_clr", 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc("t6_sat", 1'b1, 4'b0001, 32'h600, 1'b0, 1'b1);
        check("t6_cnt0", 64'(count_o[CNT_W-1:0]), 64'(CMAX));
        cyc("t6_clr2", 1'b1, 4'b0001, 32'h700, 1'b1, 1'b0);
        check("t6_clr_cnt", 64'(count_o), 64'd0);
        check("t6_clr_fsm", 64'(storm_o), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] e;
            e = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) e = 4'h0;
            cyc("rand", $urandom_range(0, 3) != 0, e, $urandom,
                $urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 5; i++)
            cyc("rst_pre", 1'b1, 4'b1010, 32'h800, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc("rst_post", 1'b1, 4'b0100, 32'h900, 1'b0, 1'b0);
        check("rst_post_ts", 64'(entry_ts_o), 64'd0);
        idle("rst_idle", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
